// File: rtl/moore_seq_detect_param_if.sv
// rtl/moore_seq_detect_param_if.sv - serial bit-stream and detector status bundle
//
// Carries the sampled serial input (en, x) toward the detector and its status
// (z, progress, match_count) back out. The master modport is the stream
// source / status consumer; the slave modport is the detector.
// Optional MOORE_SEQ_RUNTIME_PAT_EN adds pat_load / pat_in.
//
// Parameters:
//   PAT_W  pattern length (sets pat_in and progress widths)
//   CNT_W  match counter width

interface moore_seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic                       en;
    logic                       x;
    logic                       z;
    logic [$clog2(PAT_W+1)-1:0] progress;
    logic [CNT_W-1:0]           match_count;
`ifdef MOORE_SEQ_RUNTIME_PAT_EN
    logic                       pat_load;
    logic [PAT_W-1:0]           pat_in;

    modport master (output en, x, pat_load, pat_in, input z, progress, match_count);
    modport slave  (input en, x, pat_load, pat_in, output z, progress, match_count);
`else
    modport master (output en, x, input z, progress, match_count);
    modport slave  (input en, x, output z, progress, match_count);
`endif
endinterface

// File: rtl/moore_seq_detect_param.sv
// rtl/moore_seq_detect_param.sv - parametrised Moore serial sequence detector
//
// Tracks k, the length of the longest pattern prefix that is a suffix of the
// qualified bit stream. k == PAT_W is the MATCH state; z decodes it from the
// registered state only. A saturating counter counts entries into MATCH.
//
// Ports:
//   clock             rising-edge clock
//   reset             asynchronous active-low reset
//   bus.en            qualify x on this clock edge
//   bus.x             serial data bit
//   bus.z             1 while in MATCH
//   bus.progress      current k (0..PAT_W)
//   bus.match_count   saturating match count
//   bus.pat_load      (MOORE_SEQ_RUNTIME_PAT_EN) load bus.pat_in as pattern
//   bus.pat_in        (MOORE_SEQ_RUNTIME_PAT_EN) new pattern value
//
// Build option: MOORE_SEQ_RUNTIME_PAT_EN enables the runtime-loadable pattern.

module moore_seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    moore_seq_detect_param_if.slave bus
);
    localparam int               KW      = $clog2(PAT_W + 1);
    localparam logic [KW-1:0]    K_MATCH = KW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0] w_pat;
    logic             w_load;

`ifdef MOORE_SEQ_RUNTIME_PAT_EN
    logic [PAT_W-1:0] r_pat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pat <= PATTERN;
        end else if (bus.pat_load) begin
            r_pat <= bus.pat_in;
        end
    end

    assign w_pat  = r_pat;
    assign w_load = bus.pat_load;
`else
    assign w_pat  = PATTERN;
    assign w_load = 1'b0;
`endif

    logic [PAT_W-1:0] r_hist;
    logic [KW-1:0]    r_k;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_hist_shift;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [KW-1:0]    w_k_search;
    logic [KW-1:0]    w_k_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // True when the newest j history bits equal the first j pattern bits.
    function automatic logic prefix_ok(input logic [PAT_W-1:0] hist,
                                       input logic [PAT_W-1:0] pat,
                                       input int               j);
        logic [PAT_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < j) mask[i] = 1'b1;
        end
        return ((hist & mask) == ((pat >> (PAT_W - j)) & mask));
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
        end else begin
            r_hist <= w_hist_nxt;
            r_k    <= w_k_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_hist_shift = {r_hist[PAT_W-2:0], bus.x};
        w_hist_nxt   = r_hist;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_k_search   = '0;

        // Bounding j by k+1 keeps stale history bits (zeros after reset or a
        // pattern load) from ever forming a false match.
        for (int j = 1; j <= PAT_W; j++) begin
            if ((j <= int'(r_k) + 1) && prefix_ok(w_hist_shift, w_pat, j)) begin
                w_k_search = KW'(j);
            end
        end

        // Non-overlapping mode: a completed match forgets everything but x.
        if (!OVERLAP && (r_k == K_MATCH)) begin
            w_k_search = (bus.x == w_pat[PAT_W-1]) ? KW'(1) : '0;
        end

        if (w_load) begin
            w_k_nxt    = '0;
            w_hist_nxt = '0;
        end else if (bus.en) begin
            w_k_nxt    = w_k_search;
            w_hist_nxt = w_hist_shift;
            if ((w_k_search == K_MATCH) && (r_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign bus.z           = (r_k == K_MATCH);
    assign bus.progress    = r_k;
    assign bus.match_count = r_cnt;

endmodule

// File: tb/tb_moore_seq_detect_param.sv
// tb/tb_moore_seq_detect_param.sv - self-checking bench for moore_seq_detect_param

module tb_moore_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       x;
    logic       pat_load;
    logic [3:0] pin;

    int n_checks;
    int n_fail;

    moore_seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    moore_seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    moore_seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if_c ();

    assign if_a.en = en;
    assign if_a.x  = x;
    assign if_b.en = en;
    assign if_b.x  = x;
    assign if_c.en = en;
    assign if_c.x  = x;
`ifdef MOORE_SEQ_RUNTIME_PAT_EN
    assign if_a.pat_load = pat_load;
    assign if_a.pat_in   = pin;
    assign if_b.pat_load = pat_load;
    assign if_b.pat_in   = pin;
    assign if_c.pat_load = pat_load;
    assign if_c.pat_in   = pin;
`endif

    moore_seq_detect_param dut_a (.clock(clk), .reset(rst_n), .bus(if_a));
    moore_seq_detect_param #(.OVERLAP(1'b0)) dut_b (.clock(clk), .reset(rst_n), .bus(if_b));
    moore_seq_detect_param #(.CNT_W(2)) dut_c (.clock(clk), .reset(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, the bits received since the last restart
    // (newest in bit 0) and how many of them are meaningful.
    bit [3:0] mpat;
    int       mlen [3];
    int       mhist[3];
    int       mk   [3];
    int       mcnt [3];
    bit       movl [3] = '{1'b1, 1'b0, 1'b1};
    int       mmax [3] = '{255, 255, 3};

    function automatic int best_prefix(input int hist, input int len);
        int n;
        n = (len < 4) ? len : 4;
        for (int j = n; j >= 1; j--) begin
            if ((hist & ((1 << j) - 1)) == (int'(mpat) >> (4 - j))) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mpat = 4'b1001;
        for (int d = 0; d < 3; d++) begin
            mlen[d] = 0; mhist[d] = 0; mk[d] = 0; mcnt[d] = 0;
        end
    endtask

    task automatic model_step(input bit ex, input bit xx, input bit ld);
        for (int d = 0; d < 3; d++) begin
            if (ld) begin
                mlen[d] = 0; mhist[d] = 0; mk[d] = 0;
            end else if (ex) begin
                if (!movl[d] && mk[d] == 4) begin
                    mlen[d] = 0; mhist[d] = 0;
                end
                mhist[d] = ((mhist[d] << 1) | int'(xx)) & 15;
                if (mlen[d] < 4) mlen[d]++;
                mk[d] = best_prefix(mhist[d], mlen[d]);
                if (mk[d] == 4 && mcnt[d] < mmax[d]) mcnt[d]++;
            end
        end
        if (ld) mpat = pin;
    endtask

    function automatic logic [29:0] exp_vec();
        return {mk[0] == 4, 3'(mk[0]), 8'(mcnt[0]),
                mk[1] == 4, 3'(mk[1]), 8'(mcnt[1]),
                mk[2] == 4, 3'(mk[2]), 2'(mcnt[2])};
    endfunction

    function automatic logic [29:0] obs_vec();
        return {if_a.z, if_a.progress, if_a.match_count,
                if_b.z, if_b.progress, if_b.match_count,
                if_c.z, if_c.progress, if_c.match_count};
    endfunction

    // Drive one clock of stimulus; returns at the following negedge.
    task automatic cycle(input bit ex, input bit xx, input bit ld);
        en = ex; x = xx; pat_load = ld;
        @(posedge clk);
        model_step(ex, xx, ld);
        @(negedge clk);
        pat_load = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0; pat_load = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs_vec() !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), 30'd0);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        bit stream [13] = '{1,0,0,1,0,0,1,1,0,0,1,0,0};
        logic [13:0] za, zb;
        do_reset();
        za = '0; zb = '0;
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, stream[i], 1'b0);
            za[i+1] = if_a.z;
            zb[i+1] = if_b.z;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream bit %0d: got %h expected %h", i + 1, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (za !== 14'h0890) begin
            n_fail++;
            $display("FAIL stream_z_overlap: got %h expected %h", za, 14'h0890);
        end
        n_checks++;
        if (zb !== 14'h0810) begin
            n_fail++;
            $display("FAIL stream_z_no_overlap: got %h expected %h", zb, 14'h0810);
        end
        n_checks++;
        if (if_a.match_count !== 8'd3 || if_b.match_count !== 8'd2) begin
            n_fail++;
            $display("FAIL stream_counts: got %0d/%0d expected 3/2", if_a.match_count, if_b.match_count);
        end
    endtask

    task automatic test_hold();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, i[0], 1'b0);
            n_checks++;
            if (if_a.progress !== 3'd3 || if_a.z !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_progress: got k=%0d z=%b expected k=3 z=0", if_a.progress, if_a.z);
            end
        end
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (if_a.z !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold_final: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if_a.progress !== 3'd3 || if_a.match_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_pre: got k=%0d cnt=%0d expected k=3 cnt=0", if_a.progress, if_a.match_count);
        end
        cycle(1'b1, 1'b1, 1'b0);
        en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 30'd0) begin
            n_fail++;
            $display("FAIL async_immediate: got %h expected %h", obs_vec(), 30'd0);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (if_a.match_count !== 8'd1 || if_a.z !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rematch: got cnt=%0d z=%b expected cnt=1 z=1", if_a.match_count, if_a.z);
        end
    endtask

    task automatic test_saturate();
        int zc;
        do_reset();
        zc = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b1, 1'b1, 1'b0);
            zc += int'(if_c.z);
        end
        n_checks++;
        if (if_c.match_count !== 2'd3 || zc != 5) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d pulses=%0d expected cnt=3 pulses=5", if_c.match_count, zc);
        end
        n_checks++;
        if (if_a.match_count !== 8'd5) begin
            n_fail++;
            $display("FAIL saturate_wide: got cnt=%0d expected 5", if_a.match_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ((i % 97) == 96) begin
                en = 1'b0;
                #2 rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
                @(negedge clk);
            end
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef MOORE_SEQ_RUNTIME_PAT_EN
    task automatic test_runtime_pat();
        bit seq [4] = '{0,1,1,0};
        bit old [4] = '{1,0,0,1};
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (if_a.progress !== 3'd2) begin
            n_fail++;
            $display("FAIL load_pre: got k=%0d expected 2", if_a.progress);
        end
        pin = 4'b0110;
        cycle(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs_vec() !== exp_vec() || if_a.progress !== 3'd0) begin
            n_fail++;
            $display("FAIL load_clear: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, seq[i], 1'b0);
        n_checks++;
        if (if_a.z !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_newpat: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, old[i], 1'b0);
        n_checks++;
        if (if_a.z !== 1'b0 || if_a.match_count !== 8'd1) begin
            n_fail++;
            $display("FAIL load_oldpat: got z=%b cnt=%0d expected z=0 cnt=1", if_a.z, if_a.match_count);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        x        = 1'b0;
        pat_load = 1'b0;
        pin      = 4'b0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold();
        test_async_reset();
        test_saturate();
        test_random();
`ifdef MOORE_SEQ_RUNTIME_PAT_EN
        test_runtime_pat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
